// File: rtl/audio_ser_pkg.sv
// Shared constants and helpers for the serial-audio source models.
// Format codes and width-parametrised full-scale values.
package audio_ser_pkg;

  localparam logic [1:0] FMT_LJ  = 2'b00;
  localparam logic [1:0] FMT_I2S = 2'b01;
  localparam logic [1:0] FMT_TDM = 2'b10;

  // Largest positive two's-complement value for a w-bit sample.
  function automatic logic [63:0] full_scale_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value, as its w-bit pattern.
  function automatic logic [63:0] full_scale_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock generator: divides mclk into sclk and walks the slot/bit position.
// Emits tick (sclk falling), frame_start and pre_frame strobes plus the next position.
module aud_bclk_gen #(
  parameter int unsigned MCLK_DIV = 4,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned NUM_CH   = 2
) (
  input  logic                      mclk,
  input  logic                      rst_,
  output logic                      sclk,
  output logic                      tick,
  output logic                      frame_start,
  output logic                      pre_frame,
  output logic [$clog2(SLOT_W)-1:0] bit_nxt,
  output logic [$clog2(NUM_CH)-1:0] slot_nxt
);
  localparam int unsigned DIV_W   = $clog2(MCLK_DIV);
  localparam int unsigned BIT_W   = $clog2(SLOT_W);
  localparam int unsigned SLOT_CW = $clog2(NUM_CH);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SLOT_CW-1:0] slot_cnt_q, slot_cnt_d;
  logic               sclk_q, sclk_d;
  logic               last_bit, last_slot;

  always_comb begin
    tick       = (div_cnt_q == DIV_W'(MCLK_DIV - 1));
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    last_bit   = (bit_cnt_q == BIT_W'(SLOT_W - 1));
    last_slot  = (slot_cnt_q == SLOT_CW'(NUM_CH - 1));
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (tick) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
      if (last_bit) slot_cnt_d = last_slot ? '0 : slot_cnt_q + 1'b1;
    end
    sclk_d      = (div_cnt_d >= DIV_W'(MCLK_DIV / 2));
    frame_start = tick && last_bit && last_slot;
    // One mclk ahead of the frame-start tick, used to raise smp_ready in time.
    pre_frame   = (div_cnt_q == DIV_W'(MCLK_DIV - 2)) && last_bit && last_slot;
    bit_nxt     = bit_cnt_d;
    slot_nxt    = slot_cnt_d;
  end

  // Parked on the last bit of the last slot so the first tick opens frame bit 0.
  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= BIT_W'(SLOT_W - 1);
      slot_cnt_q <= SLOT_CW'(NUM_CH - 1);
      sclk_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_serial_src.sv
// Master-mode serial-audio ADC source (LJ / I2S / TDM) with ramp or external samples.
// Loads one frame buffer per frame and shifts it MSB-first on sdata.
module adc_serial_src
  import audio_ser_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned MCLK_DIV = 4
) (
  input  logic                     mclk,
  input  logic                     rst_,
  input  logic [1:0]               fmt,
  input  logic                     src_sel,
  input  logic [NUM_CH*DATA_W-1:0] smp_data,
  input  logic                     smp_valid,
  output logic                     smp_ready,
  output logic                     sclk,
  output logic                     lrck,
  output logic                     sdata,
  output logic                     ovfl_,
  output logic                     underrun
);
  localparam int unsigned BIT_W   = $clog2(SLOT_W);
  localparam int unsigned SLOT_CW = $clog2(NUM_CH);
  localparam logic [DATA_W-1:0] FS_POS = DATA_W'(full_scale_pos(DATA_W));
  localparam logic [DATA_W-1:0] FS_NEG = DATA_W'(full_scale_neg(DATA_W));

  logic               tick, frame_start, pre_frame;
  logic [BIT_W-1:0]   bit_nxt;
  logic [SLOT_CW-1:0] slot_nxt;

  logic [NUM_CH*DATA_W-1:0] ramp_q, ramp_d, buf_q, buf_d;
  logic [1:0]               fmt_q, fmt_d;
  logic                     sdata_q, sdata_d, lrck_q, lrck_d, ovfl_q, ovfl_d;
  logic                     ready_q, ready_d, under_q, under_d;
  logic [DATA_W-1:0]        cur_smp, cur_sh;
  logic [BIT_W-1:0]         sh_amt;
  logic                     is_i2s;

  aud_bclk_gen #(
    .MCLK_DIV(MCLK_DIV),
    .SLOT_W  (SLOT_W),
    .NUM_CH  (NUM_CH)
  ) u_bclk (
    .mclk       (mclk),
    .rst_       (rst_),
    .sclk       (sclk),
    .tick       (tick),
    .frame_start(frame_start),
    .pre_frame  (pre_frame),
    .bit_nxt    (bit_nxt),
    .slot_nxt   (slot_nxt)
  );

  always_comb begin
    ramp_d  = ramp_q;
    buf_d   = buf_q;
    fmt_d   = fmt_q;
    ovfl_d  = ovfl_q;
    sdata_d = sdata_q;
    lrck_d  = lrck_q;
    under_d = 1'b0;
    ready_d = pre_frame && src_sel;

    if (frame_start) begin
      fmt_d = fmt;
      if (!src_sel)                   buf_d = ramp_q;
      else if (ready_q && smp_valid)  buf_d = smp_data;
      else                            under_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (k % 2 == 0) ramp_d[k*DATA_W +: DATA_W] = ramp_q[k*DATA_W +: DATA_W] + DATA_W'(1);
        else            ramp_d[k*DATA_W +: DATA_W] = ramp_q[k*DATA_W +: DATA_W] - DATA_W'(1);
      end
      ovfl_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (buf_d[k*DATA_W +: DATA_W] == FS_POS || buf_d[k*DATA_W +: DATA_W] == FS_NEG) begin
          ovfl_d = 1'b0;
        end
      end
    end

    // Next bit is taken from the post-load buffer so frame bit 0 sees the new sample.
    cur_smp = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (slot_nxt == SLOT_CW'(k)) cur_smp = buf_d[k*DATA_W +: DATA_W];
    end
    is_i2s = (fmt_d == FMT_I2S);
    sh_amt = is_i2s ? bit_nxt - 1'b1 : bit_nxt;
    cur_sh = cur_smp << sh_amt;

    if (tick) begin
      sdata_d = (is_i2s && bit_nxt == '0) ? 1'b0 : cur_sh[DATA_W-1];
      case (fmt_d)
        FMT_I2S: lrck_d = (slot_nxt != '0);
        FMT_TDM: lrck_d = (slot_nxt == '0) && (bit_nxt == '0);
        default: lrck_d = (slot_nxt == '0);
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst_) begin
    if (!rst_) begin
      ramp_q  <= '0;
      buf_q   <= '0;
      fmt_q   <= FMT_LJ;
      sdata_q <= 1'b0;
      lrck_q  <= 1'b0;
      ovfl_q  <= 1'b1;
      ready_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      ramp_q  <= ramp_d;
      buf_q   <= buf_d;
      fmt_q   <= fmt_d;
      sdata_q <= sdata_d;
      lrck_q  <= lrck_d;
      ovfl_q  <= ovfl_d;
      ready_q <= ready_d;
      under_q <= under_d;
    end
  end

  assign smp_ready = ready_q;
  assign sdata     = sdata_q;
  assign lrck      = lrck_q;
  assign ovfl_     = ovfl_q;
  assign underrun  = under_q;

endmodule

// File: tb/tb_adc_serial_src.sv
// Bench for adc_serial_src: a 2-ch 24-bit instance (LJ/I2S/external) and an 8-ch 8-bit TDM
// instance, both compared every mclk against a frame-level model driven by edge counts.
module tb_adc_serial_src;

  localparam int P_DW [2] = '{24, 8};
  localparam int P_SW [2] = '{32, 16};
  localparam int P_NC [2] = '{2, 8};
  localparam int P_DV [2] = '{4, 2};

  logic mclk = 1'b0;
  logic rst_ = 1'b0;

  logic [1:0]  fmt_a = 2'b00, fmt_b = 2'b10;
  logic        src_a = 1'b0, src_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
  logic [47:0] data_a = '0;
  logic [63:0] data_b = '0;
  logic        ready_a, sclk_a, lrck_a, sdata_a, ovfl_a, under_a;
  logic        ready_b, sclk_b, lrck_b, sdata_b, ovfl_b, under_b;

  int n_chk = 0;
  int n_pass = 0;
  bit b_done = 1'b0;

  // Model state, per instance
  int          m_e [2];
  int          m_nf [2];
  int          m_frame [2];
  int          m_slot [2];
  int          m_bit [2];
  logic [1:0]  m_fmt [2];
  logic [63:0] m_smp [2][8];
  logic        m_sclk [2], m_sdata [2], m_lrck [2], m_ovfl [2], m_ready [2], m_under [2];

  adc_serial_src #(.DATA_W(24), .SLOT_W(32), .NUM_CH(2), .MCLK_DIV(4)) dut_a (
    .mclk(mclk), .rst_(rst_), .fmt(fmt_a), .src_sel(src_a), .smp_data(data_a),
    .smp_valid(valid_a), .smp_ready(ready_a), .sclk(sclk_a), .lrck(lrck_a),
    .sdata(sdata_a), .ovfl_(ovfl_a), .underrun(under_a)
  );

  adc_serial_src #(.DATA_W(8), .SLOT_W(16), .NUM_CH(8), .MCLK_DIV(2)) dut_b (
    .mclk(mclk), .rst_(rst_), .fmt(fmt_b), .src_sel(src_b), .smp_data(data_b),
    .smp_valid(valid_b), .smp_ready(ready_b), .sclk(sclk_b), .lrck(lrck_b),
    .sdata(sdata_b), .ovfl_(ovfl_b), .underrun(under_b)
  );

  initial forever #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  // Advance the model by one mclk edge using the inputs seen at that edge.
  task automatic step(input int i, input logic [1:0] fmt, input logic src, input logic valid,
                      input logic [191:0] data);
    int dw, sw, nc, dv, fl, q, pos, nxt, b;
    logic [63:0] mask, smp;
    logic fs;
    dw = P_DW[i]; sw = P_SW[i]; nc = P_NC[i]; dv = P_DV[i]; fl = sw * nc;
    mask = (64'd1 << dw) - 64'd1;
    if (!rst_) begin
      m_e[i] = 0; m_nf[i] = 0; m_frame[i] = -1; m_slot[i] = -1; m_bit[i] = -1;
      m_fmt[i] = 2'b00;
      for (int k = 0; k < 8; k++) m_smp[i][k] = '0;
      m_sclk[i] = 0; m_sdata[i] = 0; m_lrck[i] = 0; m_ovfl[i] = 1; m_ready[i] = 0; m_under[i] = 0;
      return;
    end
    m_e[i]++;
    m_sclk[i] = (m_e[i] % dv) >= dv / 2;
    m_under[i] = 1'b0;
    if (m_e[i] % dv == 0) begin
      q = m_e[i] / dv - 1;
      pos = q % fl;
      m_frame[i] = q / fl; m_slot[i] = pos / sw; m_bit[i] = pos % sw;
      if (pos == 0) begin
        m_fmt[i] = fmt;
        for (int k = 0; k < nc; k++) begin
          if (!src) m_smp[i][k] = (k % 2 == 0) ? (64'(m_nf[i]) & mask)
                                              : ((64'd0 - 64'(m_nf[i])) & mask);
          else if (valid) m_smp[i][k] = 64'(data >> (k * dw)) & mask;
        end
        if (src && !valid) m_under[i] = 1'b1;
        m_nf[i]++;
        fs = 1'b0;
        for (int k = 0; k < nc; k++)
          if (m_smp[i][k] == (mask >> 1) || m_smp[i][k] == (mask >> 1) + 64'd1) fs = 1'b1;
        m_ovfl[i] = !fs;
      end
      smp = m_smp[i][m_slot[i]];
      b = m_bit[i];
      if (m_fmt[i] == 2'b01) m_sdata[i] = (b >= 1 && b <= dw) ? (((smp >> (dw - b)) & 64'd1) != 0) : 1'b0;
      else m_sdata[i] = (b < dw) ? (((smp >> (dw - 1 - b)) & 64'd1) != 0) : 1'b0;
      if (m_fmt[i] == 2'b01)      m_lrck[i] = (m_slot[i] != 0);
      else if (m_fmt[i] == 2'b10) m_lrck[i] = (m_slot[i] == 0) && (b == 0);
      else                        m_lrck[i] = (m_slot[i] == 0);
    end
    nxt = m_e[i] + 1;
    m_ready[i] = src && (nxt % dv == 0) && ((nxt / dv - 1) % fl == 0);
  endtask

  // Compare process: model update on each rising edge, DUT compared 1 time unit later.
  initial begin
    forever begin
      @(posedge mclk);
      step(0, fmt_a, src_a, valid_a, 192'(data_a));
      step(1, fmt_b, src_b, valid_b, 192'(data_b));
      #1;
      chk("A.sclk", 64'(sclk_a), 64'(m_sclk[0]));
      chk("A.sdata", 64'(sdata_a), 64'(m_sdata[0]));
      chk("A.lrck", 64'(lrck_a), 64'(m_lrck[0]));
      chk("A.ovfl_", 64'(ovfl_a), 64'(m_ovfl[0]));
      chk("A.smp_ready", 64'(ready_a), 64'(m_ready[0]));
      chk("A.underrun", 64'(under_a), 64'(m_under[0]));
      chk("B.sclk", 64'(sclk_b), 64'(m_sclk[1]));
      chk("B.sdata", 64'(sdata_b), 64'(m_sdata[1]));
      chk("B.lrck", 64'(lrck_b), 64'(m_lrck[1]));
      chk("B.ovfl_", 64'(ovfl_b), 64'(m_ovfl[1]));
      chk("B.smp_ready", 64'(ready_b), 64'(m_ready[1]));
      chk("B.underrun", 64'(under_b), 64'(m_under[1]));
    end
  end

  // Wait until instance i has just entered frame f (any if f<0), slot s, bit b.
  task automatic wait_pos(input int i, input int f, input int s, input int b);
    int n;
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit) begin
      @(posedge mclk); #2;
      n++;
      if (m_frame[i] >= 0 && (f < 0 || m_frame[i] == f) && m_slot[i] == s && m_bit[i] == b &&
          m_e[i] % P_DV[i] == 0) hit = 1'b1;
      else if (n > 50000) begin
        n_chk++;
        $display("FAIL wait_pos inst%0d f%0d s%0d b%0d: got no match, want match in 50000 cycles",
                 i, f, s, b);
        hit = 1'b1;
      end
    end
  endtask

  task automatic at_a(input int f, input int s, input int b, input string name,
                      input logic act_sel, input logic exp);
    wait_pos(0, f, s, b);
    chk(name, 64'(act_sel ? lrck_a : sdata_a), 64'(exp));
  endtask

  // TDM 8-channel 8-bit instance: frame 1 layout and clip flag around the ramp wrap.
  initial begin
    wait_pos(1, 1, 0, 0);
    chk("B.f1.lrck.b0", 64'(lrck_b), 64'd1);
    chk("B.f1.c0.msb", 64'(sdata_b), 64'd0);
    wait_pos(1, 1, 0, 1);
    chk("B.f1.lrck.b1", 64'(lrck_b), 64'd0);
    wait_pos(1, 1, 0, 7);
    chk("B.f1.c0.lsb", 64'(sdata_b), 64'd1);
    wait_pos(1, 1, 1, 0);
    chk("B.f1.c1.msb", 64'(sdata_b), 64'd1);
    wait_pos(1, 1, 1, 8);
    chk("B.f1.c1.pad", 64'(sdata_b), 64'd0);
    wait_pos(1, 127, 0, 0);
    chk("B.f127.ovfl_", 64'(ovfl_b), 64'd0);
    chk("model.B.f127.c0", m_smp[1][0], 64'h7F);
    wait_pos(1, 128, 0, 0);
    chk("B.f128.ovfl_", 64'(ovfl_b), 64'd0);
    chk("B.f128.c0.msb", 64'(sdata_b), 64'd1);
    chk("model.B.f128.c1", m_smp[1][1], 64'h80);
    wait_pos(1, 129, 0, 0);
    chk("B.f129.ovfl_", 64'(ovfl_b), 64'd0);
    wait_pos(1, 130, 0, 0);
    chk("B.f130.ovfl_", 64'(ovfl_b), 64'd1);
    b_done = 1'b1;
  end

  initial begin
    repeat (3) @(posedge mclk);
    #2;
    chk("rst.A.sclk", 64'(sclk_a), 64'd0);
    chk("rst.A.lrck", 64'(lrck_a), 64'd0);
    chk("rst.A.sdata", 64'(sdata_a), 64'd0);
    chk("rst.A.ovfl_", 64'(ovfl_a), 64'd1);
    chk("rst.A.smp_ready", 64'(ready_a), 64'd0);
    chk("rst.A.underrun", 64'(under_a), 64'd0);
    @(negedge mclk) rst_ = 1'b1;

    // LJ ramp
    at_a(0, 0, 0, "A.f0.lrck.s0", 1'b1, 1'b1);
    at_a(0, 1, 0, "A.f0.lrck.s1", 1'b1, 1'b0);
    at_a(1, 0, 22, "A.f1.c0.b22", 1'b0, 1'b0);
    at_a(1, 0, 23, "A.f1.c0.lsb", 1'b0, 1'b1);
    at_a(1, 1, 0, "A.f1.c1.msb", 1'b0, 1'b1);
    chk("model.A.f1.c1", m_smp[0][1], 64'hFFFFFF);
    at_a(1, 1, 23, "A.f1.c1.lsb", 1'b0, 1'b1);
    at_a(1, 1, 24, "A.f1.c1.pad", 1'b0, 1'b0);
    at_a(2, 0, 22, "A.f2.c0.b22", 1'b0, 1'b1);
    at_a(2, 0, 23, "A.f2.c0.lsb", 1'b0, 1'b0);
    at_a(2, 1, 22, "A.f2.c1.b22", 1'b0, 1'b1);
    at_a(2, 1, 23, "A.f2.c1.lsb", 1'b0, 1'b0);

    // I2S from frame 3 (ramp 3 / -3)
    @(negedge mclk) fmt_a = 2'b01;
    at_a(3, 0, 0, "A.f3.i2s.lrck.s0", 1'b1, 1'b0);
    chk("A.f3.i2s.b0", 64'(sdata_a), 64'd0);
    at_a(3, 0, 1, "A.f3.i2s.msb", 1'b0, 1'b0);
    at_a(3, 0, 23, "A.f3.i2s.b23", 1'b0, 1'b1);
    at_a(3, 0, 24, "A.f3.i2s.lsb", 1'b0, 1'b1);
    at_a(3, 0, 25, "A.f3.i2s.pad", 1'b0, 1'b0);
    at_a(3, 1, 0, "A.f3.i2s.lrck.s1", 1'b1, 1'b1);
    at_a(3, 1, 1, "A.f3.i2s.c1.msb", 1'b0, 1'b1);
    chk("model.A.f3.c1", m_smp[0][1], 64'hFFFFFD);

    // External samples in LJ from frame 4
    wait_pos(0, 3, 1, 5);
    @(negedge mclk);
    fmt_a = 2'b00; src_a = 1'b1; valid_a = 1'b1; data_a = {24'h123456, 24'hABCDEF};
    at_a(4, 0, 0, "A.f4.ext.c0.msb", 1'b0, 1'b1);
    chk("A.f4.ovfl_", 64'(ovfl_a), 64'd1);
    chk("model.A.f4.c0", m_smp[0][0], 64'hABCDEF);
    at_a(4, 0, 1, "A.f4.ext.c0.b1", 1'b0, 1'b0);
    wait_pos(0, 4, 0, 5);
    @(negedge mclk);
    valid_a = 1'b0; data_a = 48'h0F0F0F_0F0F0F;
    at_a(4, 1, 0, "A.f4.ext.c1.msb", 1'b0, 1'b0);
    at_a(4, 1, 3, "A.f4.ext.c1.b3", 1'b0, 1'b1);
    wait_pos(0, 5, 0, 0);
    chk("A.f5.underrun", 64'(under_a), 64'd1);
    chk("A.f5.repeat.msb", 64'(sdata_a), 64'd1);
    chk("model.A.f5.c1", m_smp[0][1], 64'h123456);
    wait_pos(0, 5, 0, 1);
    chk("A.f5.underrun.end", 64'(under_a), 64'd0);
    wait_pos(0, 5, 0, 5);
    @(negedge mclk) valid_a = 1'b1;

    // Randomized frames until the TDM instance has passed its clip window
    while (!b_done) begin
      wait_pos(0, -1, 0, 10);
      @(negedge mclk);
      fmt_a   = 2'($urandom_range(0, 3));
      src_a   = 1'($urandom_range(0, 1));
      valid_a = ($urandom_range(0, 3) != 0);
      data_a  = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) data_a[23:0] = 24'h7FFFFF;
      if ($urandom_range(0, 3) == 0) data_a[47:24] = 24'h800000;
    end

    // Reset at slot 0 bit 10 aborts the frame; ramp restarts from 0
    wait_pos(0, -1, 0, 10);
    @(negedge mclk);
    rst_ = 1'b0; fmt_a = 2'b00; src_a = 1'b0; valid_a = 1'b0;
    #1;
    chk("rst2.A.sclk", 64'(sclk_a), 64'd0);
    chk("rst2.A.lrck", 64'(lrck_a), 64'd0);
    chk("rst2.A.sdata", 64'(sdata_a), 64'd0);
    chk("rst2.A.ovfl_", 64'(ovfl_a), 64'd1);
    chk("rst2.A.smp_ready", 64'(ready_a), 64'd0);
    chk("rst2.A.underrun", 64'(under_a), 64'd0);
    chk("rst2.B.ovfl_", 64'(ovfl_b), 64'd1);
    repeat (3) @(posedge mclk);
    @(negedge mclk) rst_ = 1'b1;
    at_a(0, 0, 0, "A.post.lrck", 1'b1, 1'b1);
    chk("A.post.sdata", 64'(sdata_a), 64'd0);
    chk("model.A.post.c0", m_smp[0][0], 64'h0);
    at_a(1, 0, 23, "A.post.f1.lsb", 1'b0, 1'b1);

    repeat (4) @(posedge mclk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
